// File: rtl/tl_master_port.sv
// tl_master_port: TileLink-UL initiator with one outstanding transaction.
// A single-beat request becomes a Get, PutFullData or PutPartialData on
// channel A. The matching channel D response is returned on the rsp port.
// Source IDs roll over, and a response timeout abandons a transaction
// whose response never arrives.
module tl_master_port #(
   parameter int TL_ADDR_BITS   = 32,
   parameter int TL_DATA_BYTES  = 4,
   parameter int TL_SIZE_BITS   = 3,
   parameter int TL_SOURCE_BITS = 4,
   parameter int TL_SINK_BITS   = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   // processor-side request
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic                         req_full,
   input  logic [TL_ADDR_BITS-1:0]      req_addr,
   input  logic [TL_SIZE_BITS-1:0]      req_size,
   input  logic [TL_DATA_BYTES-1:0]     req_wmask,
   input  logic [TL_DATA_BYTES*8-1:0]   req_wdata,
   // processor-side response
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [TL_DATA_BYTES*8-1:0]   rsp_rdata,
   output logic                         rsp_error,
   // channel A
   output logic                         a_valid,
   input  logic                         a_ready,
   output logic [2:0]                   a_opcode,
   output logic [2:0]                   a_param,
   output logic [TL_SIZE_BITS-1:0]      a_size,
   output logic [TL_SOURCE_BITS-1:0]    a_source,
   output logic [TL_ADDR_BITS-1:0]      a_address,
   output logic [TL_DATA_BYTES-1:0]     a_mask,
   output logic [TL_DATA_BYTES*8-1:0]   a_data,
   // channel D
   input  logic                         d_valid,
   output logic                         d_ready,
   input  logic [3:0]                   d_opcode,
   input  logic [1:0]                   d_param,
   input  logic [TL_SIZE_BITS-1:0]      d_size,
   input  logic [TL_SOURCE_BITS-1:0]    d_source,
   input  logic [TL_SINK_BITS-1:0]     d_sink,
   input  logic                         d_denied,
   input  logic [TL_DATA_BYTES*8-1:0]   d_data,
   // status
   output logic                         busy,
   output logic                         err_unexpected,
   output logic                         err_timeout
);

   localparam logic [2:0] TL_A_GET           = 3'd4;
   localparam logic [2:0] TL_A_PUTFULL       = 3'd0;
   localparam logic [2:0] TL_A_PUTPARTIAL    = 3'd1;
   localparam logic [3:0] TL_D_ACCESSACK     = 4'd0;
   localparam logic [3:0] TL_D_ACCESSACKDATA = 4'd1;

   // Last timer value of D_WAIT before giving up. It is unused when the timeout is disabled.
   localparam logic [15:0] TIMER_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_A_SEND = 2'd1,
      ST_D_WAIT = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t                        state_r;
   logic [2:0]                    opcode_r;
   logic [TL_ADDR_BITS-1:0]       addr_r;
   logic [TL_SIZE_BITS-1:0]       size_r;
   logic [TL_DATA_BYTES-1:0]      mask_r;
   logic [TL_DATA_BYTES*8-1:0]    data_r;
   logic [TL_SOURCE_BITS-1:0]     src_cnt_r;
   logic [TL_SOURCE_BITS-1:0]     cur_src_r;
   logic [15:0]                   timer_r;
   logic [TL_DATA_BYTES*8-1:0]    rsp_rdata_r;
   logic                          rsp_error_r;
   logic                          err_unexpected_r;
   logic                          err_timeout_r;

   logic                          is_get_s;
   logic [3:0]                    exp_d_opcode_s;
   logic                          d_match_s;
   logic                          timeout_s;
   logic                          unused_ok_s;

   // Expected D opcode for a given A opcode: reads return data, writes do not.
   function automatic logic [3:0] expected_d_opcode(input logic [2:0] a_op);
      logic [3:0] res;
      case (a_op)
         TL_A_GET: res = TL_D_ACCESSACKDATA;
         default:  res = TL_D_ACCESSACK;
      endcase
      return res;
   endfunction

   // Param, size and sink of channel D carry nothing this initiator needs.
   assign unused_ok_s = ^{d_param, d_size, d_sink};

   // Decide whether the current D beat belongs to us and whether the wait has expired.
   always_comb begin
      is_get_s       = 1'b0;
      exp_d_opcode_s = expected_d_opcode(opcode_r);
      d_match_s      = 1'b0;
      timeout_s      = 1'b0;
      if (opcode_r == TL_A_GET) begin
         is_get_s = 1'b1;
      end else begin
         is_get_s = 1'b0;
      end
      if (d_valid && (d_source == cur_src_r) && (d_opcode == exp_d_opcode_s)) begin
         d_match_s = 1'b1;
      end else begin
         d_match_s = 1'b0;
      end
      if ((TIMEOUT_CYCLES != 0) && (timer_r == TIMER_LAST)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Transaction FSM: captures the request, runs channels A and D, and holds the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r          <= ST_IDLE;
         opcode_r         <= 3'd0;
         addr_r           <= '0;
         size_r           <= '0;
         mask_r           <= '0;
         data_r           <= '0;
         src_cnt_r        <= '0;
         cur_src_r        <= '0;
         timer_r          <= 16'd0;
         rsp_rdata_r      <= '0;
         rsp_error_r      <= 1'b0;
         err_unexpected_r <= 1'b0;
         err_timeout_r    <= 1'b0;
      end else begin
         err_unexpected_r <= 1'b0;
         err_timeout_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Any D beat here is stale, for example a response arriving after a timeout.
               if (d_valid) begin
                  err_unexpected_r <= 1'b1;
               end
               if (req_valid) begin
                  if (req_write) begin
                     opcode_r <= req_full ? TL_A_PUTFULL : TL_A_PUTPARTIAL;
                     data_r   <= req_wdata;
                  end else begin
                     opcode_r <= TL_A_GET;
                     data_r   <= '0;
                  end
                  addr_r    <= req_addr;
                  size_r    <= req_size;
                  mask_r    <= req_wmask;
                  cur_src_r <= src_cnt_r;
                  state_r   <= ST_A_SEND;
               end
            end
            ST_A_SEND: begin
               if (d_valid) begin
                  err_unexpected_r <= 1'b1;
               end
               if (a_ready) begin
                  src_cnt_r <= src_cnt_r + {{(TL_SOURCE_BITS-1){1'b0}}, 1'b1};
                  timer_r   <= 16'd0;
                  state_r   <= ST_D_WAIT;
               end
            end
            ST_D_WAIT: begin
               timer_r <= timer_r + 16'd1;
               if (d_match_s) begin
                  // A denied read carries no meaningful data, so it is zeroed like a put.
                  rsp_rdata_r <= (is_get_s && !d_denied) ? d_data : '0;
                  rsp_error_r <= d_denied;
                  state_r     <= ST_RESP;
               end else begin
                  if (d_valid) begin
                     err_unexpected_r <= 1'b1;
                  end
                  if (timeout_s) begin
                     rsp_rdata_r   <= '0;
                     rsp_error_r   <= 1'b1;
                     err_timeout_r <= 1'b1;
                     state_r       <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Handshake outputs are pure decodes of the state register.
   assign req_ready = (state_r == ST_IDLE);
   assign a_valid   = (state_r == ST_A_SEND);
   assign d_ready   = (state_r != ST_RESP);
   assign rsp_valid = (state_r == ST_RESP);
   assign busy      = (state_r != ST_IDLE);

   assign a_opcode  = opcode_r;
   assign a_param   = 3'd0;
   assign a_size    = size_r;
   assign a_source  = cur_src_r;
   assign a_address = addr_r;
   assign a_mask    = mask_r;
   assign a_data    = data_r;

   assign rsp_rdata      = rsp_rdata_r;
   assign rsp_error      = rsp_error_r;
   assign err_unexpected = err_unexpected_r;
   assign err_timeout    = err_timeout_r;

endmodule

// File: tb/tb_tl_master_port.sv
// Testbench for tl_master_port: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_tl_master_port;
   localparam int AW   = 32;
   localparam int DB   = 4;
   localparam int SW   = 3;
   localparam int SRCW = 4;
   localparam int SKW  = 2;
   localparam int TMO  = 8;

   logic            clk, rst;
   logic            req_valid, req_ready, req_write, req_full;
   logic [AW-1:0]   req_addr;
   logic [SW-1:0]   req_size;
   logic [DB-1:0]   req_wmask;
   logic [DB*8-1:0] req_wdata;
   logic            rsp_valid, rsp_ready, rsp_error;
   logic [DB*8-1:0] rsp_rdata;
   logic            a_valid, a_ready;
   logic [2:0]      a_opcode, a_param;
   logic [SW-1:0]   a_size;
   logic [SRCW-1:0] a_source;
   logic [AW-1:0]   a_address;
   logic [DB-1:0]   a_mask;
   logic [DB*8-1:0] a_data;
   logic            d_valid, d_ready, d_denied;
   logic [3:0]      d_opcode;
   logic [1:0]      d_param;
   logic [SW-1:0]   d_size;
   logic [SRCW-1:0] d_source;
   logic [SKW-1:0]  d_sink;
   logic [DB*8-1:0] d_data;
   logic            busy, err_unexpected, err_timeout;

   tl_master_port #(
      .TL_ADDR_BITS(AW), .TL_DATA_BYTES(DB), .TL_SIZE_BITS(SW),
      .TL_SOURCE_BITS(SRCW), .TL_SINK_BITS(SKW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_full(req_full),
      .req_addr(req_addr), .req_size(req_size), .req_wmask(req_wmask), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
      .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
      .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data),
      .busy(busy), .err_unexpected(err_unexpected), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // TileLink opcode values
   localparam logic [2:0] OP_GET  = 3'd4;
   localparam logic [2:0] OP_PUTF = 3'd0;
   localparam logic [2:0] OP_PUTP = 3'd1;
   localparam logic [3:0] D_ACK   = 4'd0;
   localparam logic [3:0] D_ACKD  = 4'd1;

   int checks = 0;
   int errors = 0;
   int unexp_cnt = 0;
   int tmo_cnt = 0;
   logic [SRCW-1:0] exp_src;   // model: next source ID the port should use

   // observations from the most recent run_txn
   logic [2:0]      obs_opcode, obs_param;
   logic [SW-1:0]   obs_size;
   logic [SRCW-1:0] obs_source;
   logic [AW-1:0]   obs_addr;
   logic [DB-1:0]   obs_mask;
   logic [DB*8-1:0] obs_data, obs_rdata;
   logic            obs_error, obs_a_seen, obs_stable, obs_got_rsp, obs_dready_rsp;
   int              obs_cycles;

   // Pulse counters, sampled shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      if (err_unexpected === 1'b1) unexp_cnt++;
      if (err_timeout === 1'b1) tmo_cnt++;
   end

   // Drives one complete transaction as requester and slave; the caller sits just after a negedge.
   task automatic run_txn(input bit wr, input bit full, input logic [AW-1:0] addr,
                          input logic [SW-1:0] size, input logic [DB-1:0] mask,
                          input logic [DB*8-1:0] wdata, input int a_wait, input int d_wait,
                          input int n_junk, input logic [DB*8-1:0] rdata, input bit denied);
      int cyc;
      cyc = 0;
      req_valid = 1'b1; req_write = wr; req_full = full; req_addr = addr;
      req_size = size; req_wmask = mask; req_wdata = wdata;
      @(negedge clk); cyc++;
      req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
      obs_a_seen = a_valid; obs_opcode = a_opcode; obs_param = a_param; obs_size = a_size;
      obs_source = a_source; obs_addr = a_address; obs_mask = a_mask; obs_data = a_data;
      obs_stable = 1'b1;
      for (int i = 0; i < a_wait; i++) begin
         @(negedge clk); cyc++;
         if (a_valid !== 1'b1 || a_opcode !== obs_opcode || a_address !== obs_addr ||
             a_mask !== obs_mask || a_data !== obs_data || a_source !== obs_source ||
             a_size !== obs_size) obs_stable = 1'b0;
      end
      a_ready = 1'b1;
      @(negedge clk); cyc++;
      a_ready = 1'b0;
      for (int j = 0; j < n_junk; j++) begin
         d_valid = 1'b1; d_denied = 1'b0; d_data = $urandom;
         if (j % 2 == 0) begin
            d_source = obs_source + 4'd1; d_opcode = wr ? D_ACK : D_ACKD;
         end else begin
            d_source = obs_source; d_opcode = wr ? D_ACKD : D_ACK;
         end
         @(negedge clk); cyc++;
      end
      d_valid = 1'b0;
      for (int k = 0; k < d_wait; k++) begin
         @(negedge clk); cyc++;
      end
      d_valid = 1'b1; d_source = obs_source; d_opcode = wr ? D_ACK : D_ACKD;
      d_data = rdata; d_denied = denied;
      d_param = 2'($urandom); d_size = 3'($urandom); d_sink = 2'($urandom);
      @(negedge clk); cyc++;
      d_valid = 1'b0; d_data = $urandom; d_denied = 1'b0;
      obs_got_rsp = 1'b0;
      for (int w = 0; w < 20 && !obs_got_rsp; w++) begin
         if (rsp_valid === 1'b1) obs_got_rsp = 1'b1;
         else begin
            @(negedge clk); cyc++;
         end
      end
      obs_cycles = cyc; obs_rdata = rsp_rdata; obs_error = rsp_error; obs_dready_rsp = d_ready;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_full = 1'b0; req_addr = '0; req_size = '0;
      req_wmask = '0; req_wdata = '0; rsp_ready = 1'b0; a_ready = 1'b0; d_valid = 1'b0;
      d_opcode = 4'd0; d_param = 2'd0; d_size = '0; d_source = '0; d_sink = '0;
      d_denied = 1'b0; d_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, busy, a_valid, rsp_valid, err_unexpected, err_timeout, d_ready} !== 7'b1000001) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 1000001", {req_ready, busy, a_valid, rsp_valid, err_unexpected, err_timeout, d_ready});
      end
      checks++;
      if (rsp_rdata !== 32'd0 || rsp_error !== 1'b0 || a_source !== 4'd0 || a_address !== 32'd0 || a_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_regs rdata=%h err=%b src=%h addr=%h data=%h want all 0", rsp_rdata, rsp_error, a_source, a_address, a_data);
      end
      rst = 1'b0;
      exp_src = '0;
      @(negedge clk);
   endtask

   task automatic test_get_basic();
      run_txn(1'b0, 1'b0, 32'h100, 3'd2, 4'hF, 32'h0, 0, 0, 0, 32'hDEADBEEF, 1'b0);
      checks++;
      if (obs_opcode !== OP_GET || obs_source !== 4'd0 || obs_data !== 32'd0 || obs_addr !== 32'h100) begin
         errors++;
         $display("FAIL get_a op=%0d src=%0d data=%h addr=%h want 4 0 0 100", obs_opcode, obs_source, obs_data, obs_addr);
      end
      checks++;
      if (obs_got_rsp !== 1'b1 || obs_rdata !== 32'hDEADBEEF || obs_error !== 1'b0) begin
         errors++;
         $display("FAIL get_rsp got=%b rdata=%h err=%b want 1 deadbeef 0", obs_got_rsp, obs_rdata, obs_error);
      end
      checks++;
      if (obs_cycles != 3) begin
         errors++;
         $display("FAIL get_roundtrip got %0d want 3", obs_cycles);
      end
      checks++;
      if (obs_dready_rsp !== 1'b0) begin
         errors++;
         $display("FAIL get_dready_resp got %b want 0", obs_dready_rsp);
      end
      exp_src = exp_src + 4'd1;
   endtask

   task automatic test_put_partial();
      run_txn(1'b1, 1'b0, 32'h200, 3'd2, 4'h0F, 32'h12345678, 4, 0, 0, 32'hCAFEF00D, 1'b0);
      checks++;
      if (obs_a_seen !== 1'b1 || obs_stable !== 1'b1) begin
         errors++;
         $display("FAIL put_stable seen=%b stable=%b want 1 1", obs_a_seen, obs_stable);
      end
      checks++;
      if (obs_opcode !== OP_PUTP || obs_mask !== 4'h0F || obs_data !== 32'h12345678 || obs_source !== exp_src) begin
         errors++;
         $display("FAIL put_a op=%0d mask=%h data=%h src=%0d want 1 f 12345678 %0d", obs_opcode, obs_mask, obs_data, obs_source, exp_src);
      end
      checks++;
      if (obs_got_rsp !== 1'b1 || obs_rdata !== 32'd0 || obs_error !== 1'b0) begin
         errors++;
         $display("FAIL put_rsp got=%b rdata=%h err=%b want 1 0 0", obs_got_rsp, obs_rdata, obs_error);
      end
      exp_src = exp_src + 4'd1;
   endtask

   task automatic test_wrong_source();
      int u0;
      u0 = unexp_cnt;
      run_txn(1'b0, 1'b0, 32'h300, 3'd2, 4'hF, 32'h0, 0, 1, 1, 32'h0BADF00D, 1'b0);
      checks++;
      if (unexp_cnt - u0 != 1) begin
         errors++;
         $display("FAIL wrongsrc_pulses got %0d want 1", unexp_cnt - u0);
      end
      checks++;
      if (obs_got_rsp !== 1'b1 || obs_rdata !== 32'h0BADF00D || obs_error !== 1'b0) begin
         errors++;
         $display("FAIL wrongsrc_rsp got=%b rdata=%h err=%b want 1 0badf00d 0", obs_got_rsp, obs_rdata, obs_error);
      end
      exp_src = exp_src + 4'd1;
   endtask

   task automatic test_timeout();
      int t0, first;
      logic [SRCW-1:0] src;
      t0 = tmo_cnt; first = -1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400; req_size = 3'd2; req_wmask = 4'hF;
      @(negedge clk);
      req_valid = 1'b0; src = a_source; a_ready = 1'b1;
      @(negedge clk);
      a_ready = 1'b0;
      exp_src = exp_src + 4'd1;
      for (int k = 1; k <= 20 && first < 0; k++) begin
         @(negedge clk);
         if (err_timeout === 1'b1) first = k;
      end
      checks++;
      if (first != TMO) begin
         errors++;
         $display("FAIL timeout_delay got %0d want %0d", first, TMO);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'd0 || tmo_cnt - t0 != 1) begin
         errors++;
         $display("FAIL timeout_rsp valid=%b err=%b rdata=%h pulses=%0d want 1 1 0 1", rsp_valid, rsp_error, rsp_rdata, tmo_cnt - t0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      d_valid = 1'b1; d_source = src; d_opcode = D_ACKD; d_data = 32'h11112222;
      @(negedge clk);
      d_valid = 1'b0;
      checks++;
      if (err_unexpected !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL late_beat unexp=%b busy=%b rsp=%b want 1 0 0", err_unexpected, busy, rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500;
      @(negedge clk);
      req_valid = 1'b0; a_ready = 1'b1;
      @(negedge clk);
      a_ready = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid busy=%b req_ready=%b rsp=%b want 0 1 0", busy, req_ready, rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0; exp_src = '0;
      d_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_norsp got %b want 0", rsp_valid);
      end
      run_txn(1'b0, 1'b0, 32'h600, 3'd2, 4'hF, 32'h0, 0, 0, 0, 32'h600D600D, 1'b0);
      checks++;
      if (obs_source !== 4'd0 || obs_rdata !== 32'h600D600D) begin
         errors++;
         $display("FAIL reset_mid_src src=%0d rdata=%h want 0 600d600d", obs_source, obs_rdata);
      end
      exp_src = exp_src + 4'd1;
   endtask

   task automatic test_source_wrap();
      logic [SRCW-1:0] want;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; exp_src = '0;
      for (int i = 0; i <= (1 << SRCW); i++) begin
         run_txn(1'b0, 1'b0, 32'($urandom), 3'd2, 4'hF, 32'h0, 0, 0, 0, 32'($urandom), 1'b0);
         want = SRCW'(i);
         checks++;
         if (obs_source !== want) begin
            errors++;
            $display("FAIL wrap_src[%0d] got %0d want %0d", i, obs_source, want);
         end
         exp_src = exp_src + 4'd1;
      end
      run_txn(1'b0, 1'b0, 32'h700, 3'd2, 4'hF, 32'h0, 0, 0, 0, 32'h0, 1'b1);
      checks++;
      if (obs_got_rsp !== 1'b1 || obs_error !== 1'b1 || obs_rdata !== 32'd0) begin
         errors++;
         $display("FAIL denied got=%b err=%b rdata=%h want 1 1 0", obs_got_rsp, obs_error, obs_rdata);
      end
      exp_src = exp_src + 4'd1;
   endtask

   task automatic test_back_to_back();
      run_txn(1'b1, 1'b1, 32'h800, 3'd2, 4'hF, 32'hA5A5A5A5, 0, 0, 0, 32'h0, 1'b0);
      exp_src = exp_src + 4'd1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready got %b want 1", req_ready);
      end
      run_txn(1'b0, 1'b0, 32'h804, 3'd2, 4'hF, 32'h0, 0, 0, 0, 32'h5A5A5A5A, 1'b0);
      checks++;
      if (obs_cycles != 3 || obs_rdata !== 32'h5A5A5A5A || obs_source !== exp_src) begin
         errors++;
         $display("FAIL b2b_second cyc=%0d rdata=%h src=%0d want 3 5a5a5a5a %0d", obs_cycles, obs_rdata, obs_source, exp_src);
      end
      exp_src = exp_src + 4'd1;
   endtask

   task automatic test_random();
      bit wr, full, den;
      logic [AW-1:0] addr; logic [SW-1:0] size; logic [DB-1:0] mask;
      logic [DB*8-1:0] wd, rd, exp_rd, exp_wd;
      logic [2:0] exp_op;
      int aw, dw, nj, u0;
      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom); full = 1'($urandom); den = ($urandom_range(0, 7) == 0);
         addr = $urandom; size = 3'($urandom_range(0, 2)); mask = 4'($urandom);
         wd = $urandom; rd = den ? 32'd0 : 32'($urandom);
         aw = $urandom_range(0, 3); dw = $urandom_range(0, 3); nj = $urandom_range(0, 2);
         exp_op = wr ? (full ? OP_PUTF : OP_PUTP) : OP_GET;
         exp_wd = wr ? wd : 32'd0;
         exp_rd = (wr || den) ? 32'd0 : rd;
         u0 = unexp_cnt;
         run_txn(wr, full, addr, size, mask, wd, aw, dw, nj, rd, den);
         checks++;
         if (obs_opcode !== exp_op || obs_addr !== addr || obs_size !== size || obs_mask !== mask ||
             obs_data !== exp_wd || obs_param !== 3'd0 || obs_source !== exp_src || obs_stable !== 1'b1) begin
            errors++;
            $display("FAIL rand_a[%0d] op=%0d/%0d addr=%h/%h data=%h/%h src=%0d/%0d stable=%b",
                     n, obs_opcode, exp_op, obs_addr, addr, obs_data, exp_wd, obs_source, exp_src, obs_stable);
         end
         checks++;
         if (obs_got_rsp !== 1'b1 || obs_rdata !== exp_rd || obs_error !== den || unexp_cnt - u0 != nj) begin
            errors++;
            $display("FAIL rand_rsp[%0d] got=%b rdata=%h/%h err=%b/%b unexp=%0d/%0d",
                     n, obs_got_rsp, obs_rdata, exp_rd, obs_error, den, unexp_cnt - u0, nj);
         end
         exp_src = exp_src + 4'd1;
      end
   endtask

   initial begin
      test_reset();
      test_get_basic();
      test_put_partial();
      test_wrong_source();
      test_timeout();
      test_reset_mid();
      test_source_wrap();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
